// File: rtl/mp_addsub_iter.sv
// mp_addsub_iter: multi-cycle, limb-serial wide add/subtract.
// One LIMB_W-bit slice of the operands is summed per cycle. The carry between
// slices is held in a register, so the adder only needs to be LIMB_W bits wide.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            request; accepted only in IDLE or DONE
//   subtract         0: A+B, 1: A-B (captured with start)
//   in_a, in_b       WIDTH-bit operands (captured with start)
//   result           WIDTH+1 bits {carry/borrow, sum}; held until the next op completes
//   done             one-cycle pulse, result valid
//   busy             high while the operation runs
//   last             combinational: high in the final run cycle
//   zero             result[WIDTH-1:0]==0, only when MPADD_ZERO_FLAG_EN is defined
//
// Optional feature macro: MPADD_ZERO_FLAG_EN (adds the zero flag port and logic).
module mp_addsub_iter #(
  parameter int unsigned WIDTH  = 1027,
  parameter int unsigned LIMB_W = 514
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy,
  output logic             last
`ifdef MPADD_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam int unsigned NLIMB = (EXT_W + LIMB_W - 1) / LIMB_W;
  localparam int unsigned PAD_W = NLIMB * LIMB_W;
  localparam int unsigned CNT_W = $clog2(NLIMB) + 1;
  localparam int unsigned SUM_W = LIMB_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NLIMB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAD_W-1:0]   a_q, a_d;
  logic [PAD_W-1:0]   b_q, b_d;
  logic [PAD_W-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [WIDTH:0]     res_q, res_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [SUM_W-1:0]   limb_c;

`ifdef MPADD_ZERO_FLAG_EN
  // Ones over the bits that contribute to the zero flag (below WIDTH).
  localparam logic [PAD_W-1:0] ZMASK = PAD_W'({WIDTH{1'b1}});
  logic               zacc_q, zacc_d;
  logic               zero_q, zero_d;
  logic [LIMB_W-1:0]  zmask_c;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MPADD_ZERO_FLAG_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MPADD_ZERO_FLAG_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
`endif
    end
  end

  // Next-state, limb adder and shift datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    res_d   = res_q;
`ifdef MPADD_ZERO_FLAG_EN
    zacc_d  = zacc_q;
    zero_d  = zero_q;
    zmask_c = LIMB_W'(ZMASK >> (32'(cnt_q) * LIMB_W));
`endif

    // carry_q holds cin0 (the subtract flag) in the first run cycle.
    limb_c = {1'b0, a_q[LIMB_W-1:0]} + {1'b0, b_q[LIMB_W-1:0]} + SUM_W'(carry_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = PAD_W'(in_a);
          // Inverting over the padded width keeps the padding consistent for two's complement.
          b_d     = subtract ? ~(PAD_W'(in_b)) : PAD_W'(in_b);
          carry_d = subtract;
`ifdef MPADD_ZERO_FLAG_EN
          zacc_d  = 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> LIMB_W;
        b_d     = b_q >> LIMB_W;
        carry_d = limb_c[LIMB_W];
        // New limb enters at the top; after NLIMB cycles limb 0 sits at bit 0.
        acc_d   = (acc_q >> LIMB_W) | (PAD_W'(limb_c[LIMB_W-1:0]) << (PAD_W - LIMB_W));
`ifdef MPADD_ZERO_FLAG_EN
        zacc_d  = zacc_q & ~(|(limb_c[LIMB_W-1:0] & zmask_c));
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = acc_d[WIDTH:0];
`ifdef MPADD_ZERO_FLAG_EN
          zero_d  = zacc_d;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign result = res_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign last   = (state_q == S_RUN) && (cnt_q == CNT_LAST);
`ifdef MPADD_ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

endmodule
